// File: rtl/riscv_fpga_cpu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fpga_imem / riscv_fpga_cpu
// Brief    : Single-cycle RV32I core with on-chip ROM/RAM, driving a
//            multiplexed 8-digit 7-segment hex display of a selected value.
// Revision : 1.0 - initial release
// ============================================================================

module riscv_fpga_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] RAM [0:DEPTH-1];

    // Write port exists for in-system loading; the CPU top ties it off.
    always_ff @(posedge clk) begin
        if (we) RAM[waddr] <= wdata;
    end

    assign rdata = RAM[raddr];
endmodule

module riscv_fpga_cpu #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int SCAN_DIV   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switches,
    output logic [7:0]  disp_seg_o,
    output logic [7:0]  disp_an_o
);
    localparam int c_IAW = $clog2(IMEM_DEPTH);
    localparam int c_DAW = $clog2(DMEM_DEPTH);
    localparam logic [6:0] c_OP_LUI = 7'h37, c_OP_AUIPC = 7'h17, c_OP_JAL = 7'h6F,
                           c_OP_JALR = 7'h67, c_OP_BR = 7'h63, c_OP_LOAD = 7'h03,
                           c_OP_STORE = 7'h23, c_OP_IMM = 7'h13, c_OP_REG = 7'h33;

    logic [31:0]         r_pc;
    logic [31:0]         r_regs [0:31];
    logic [31:0]         dataMem [0:DMEM_DEPTH-1];
    logic [SCAN_DIV-1:0] r_div;
    logic [2:0]          r_idx;
    logic [7:0]          r_seg, r_an;

    logic [31:0] w_instr, w_rs1_val, w_rs2_val, w_op_b, w_alu_res, w_mem_addr;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_pc_plus4;
    logic [31:0] w_next_pc, w_rd_data, w_disp_val;
    logic [6:0]  w_opcode, w_f7, w_glyph;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]  w_f3;
    logic [3:0]  w_nibble;
    logic        w_is_r, w_alu_legal, w_take, w_br_legal, w_rd_we, w_mem_we, w_unused;
    logic [c_DAW-1:0] w_mem_idx;

    riscv_fpga_imem #(.DEPTH(IMEM_DEPTH), .AW(c_IAW)) instrMem (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (r_pc[c_IAW+1:2]),
        .rdata (w_instr)
    );

    assign w_opcode   = w_instr[6:0];
    assign w_rd       = w_instr[11:7];
    assign w_f3       = w_instr[14:12];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];
    assign w_f7       = w_instr[31:25];
    assign w_imm_i    = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b    = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u    = {w_instr[31:12], 12'b0};
    assign w_imm_j    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_is_r     = (w_opcode == c_OP_REG);
    assign w_op_b     = w_is_r ? w_rs2_val : w_imm_i;
    assign w_shamt    = w_is_r ? w_rs2_val[4:0] : w_instr[24:20];
    assign w_mem_addr = w_rs1_val + ((w_opcode == c_OP_STORE) ? w_imm_s : w_imm_i);
    assign w_mem_idx  = w_mem_addr[c_DAW+1:2];
    assign w_unused   = ^{switches, w_mem_addr, r_pc};

    always_comb begin
        w_alu_legal = 1'b1;
        case (w_f3)
            3'b000:  w_alu_res = (w_is_r && w_instr[30]) ? w_rs1_val - w_op_b : w_rs1_val + w_op_b;
            3'b001:  w_alu_res = w_rs1_val << w_shamt;
            3'b010:  w_alu_res = {31'b0, $signed(w_rs1_val) < $signed(w_op_b)};
            3'b011:  w_alu_res = {31'b0, w_rs1_val < w_op_b};
            3'b100:  w_alu_res = w_rs1_val ^ w_op_b;
            3'b101:  w_alu_res = w_instr[30] ? $unsigned($signed(w_rs1_val) >>> w_shamt)
                                             : w_rs1_val >> w_shamt;
            3'b110:  w_alu_res = w_rs1_val | w_op_b;
            default: w_alu_res = w_rs1_val & w_op_b;
        endcase
        // funct7 only matters for register ops and the immediate shifts
        if (w_is_r)
            w_alu_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101));
        else if (w_f3 == 3'b001)
            w_alu_legal = (w_f7 == 7'h00);
        else if (w_f3 == 3'b101)
            w_alu_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
    end

    always_comb begin
        w_br_legal = 1'b1;
        case (w_f3)
            3'b000:  w_take = (w_rs1_val == w_rs2_val);
            3'b001:  w_take = (w_rs1_val != w_rs2_val);
            3'b100:  w_take = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_take = (w_rs1_val <  w_rs2_val);
            3'b111:  w_take = (w_rs1_val >= w_rs2_val);
            default: begin w_take = 1'b0; w_br_legal = 1'b0; end
        endcase
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        w_rd_we   = 1'b0;
        w_rd_data = '0;
        w_mem_we  = 1'b0;
        case (w_opcode)
            c_OP_LUI:   begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
            c_OP_AUIPC: begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
            c_OP_JAL:   begin w_rd_we = 1'b1; w_rd_data = w_pc_plus4; w_next_pc = r_pc + w_imm_j; end
            c_OP_JALR:  if (w_f3 == 3'b000) begin
                            w_rd_we   = 1'b1;
                            w_rd_data = w_pc_plus4;
                            w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
                        end
            c_OP_BR:    if (w_br_legal && w_take) w_next_pc = r_pc + w_imm_b;
            c_OP_LOAD:  if (w_f3 == 3'b010) begin w_rd_we = 1'b1; w_rd_data = dataMem[w_mem_idx]; end
            c_OP_STORE: w_mem_we = (w_f3 == 3'b010);
            c_OP_IMM, c_OP_REG: begin w_rd_we = w_alu_legal; w_rd_data = w_alu_res; end
            default:    ;
        endcase
    end

    always_comb begin
        case (switches[1:0])
            2'b00:   w_disp_val = r_pc;
            2'b01:   w_disp_val = w_instr;
            2'b10:   w_disp_val = (switches[6:2] == 5'd0) ? 32'd0 : r_regs[switches[6:2]];
            default: w_disp_val = dataMem[switches[c_DAW+1:2]];
        endcase
        w_nibble = w_disp_val[{r_idx, 2'b00} +: 4];
        case (w_nibble)
            4'h0: w_glyph = 7'h40;  4'h1: w_glyph = 7'h79;  4'h2: w_glyph = 7'h24;  4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;  4'h5: w_glyph = 7'h12;  4'h6: w_glyph = 7'h02;  4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;  4'h9: w_glyph = 7'h10;  4'hA: w_glyph = 7'h08;  4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;  4'hD: w_glyph = 7'h21;  4'hE: w_glyph = 7'h06;  default: w_glyph = 7'h0E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc  <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            r_div <= '0;
            r_idx <= '0;
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_pc <= w_next_pc;
            if (w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_data;
            r_div <= r_div + SCAN_DIV'(1);
            if (&r_div) r_idx <= r_idx + 3'd1;
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= {1'b1, w_glyph};
        end
    end

    // Data RAM has no reset; stores are simply suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && w_mem_we) dataMem[w_mem_idx] <= w_rs2_val;
    end

    assign disp_seg_o = r_seg;
    assign disp_an_o  = r_an;
endmodule

`default_nettype wire

// File: tb/tb_riscv_fpga_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_fpga_cpu
// Brief    : Self-checking bench for riscv_fpga_cpu against an instruction-
//            level reference model and a display-scan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fpga_cpu;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [15:0] switches = 16'h0000;
    logic [7:0] disp_seg_o, disp_an_o;
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    riscv_fpga_cpu #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .SCAN_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .switches   (switches),
        .disp_seg_o (disp_seg_o),
        .disp_an_o  (disp_an_o)
    );

    always #5 clk = ~clk;

    logic [31:0] m_imem [256];
    logic [31:0] m_dmem [256];
    logic [31:0] m_x    [32];
    logic [31:0] m_pc;

    function automatic logic [31:0] f_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] f_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] f_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] f_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] f_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        m_imem[a] = w;
        dut.instrMem.RAM[a] = w;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) put(i, c_NOP);
    endtask

    task automatic set_dmem(input int a, input logic [31:0] v);
        m_dmem[a] = v;
        dut.dataMem[a] = v;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
    endtask

    // Architectural reference: executes one instruction on the model state.
    task automatic model_step();
        logic [31:0] ins, a, b, ii, is, ib, nxt, val, ea;
        logic [6:0] op, f7;
        logic [4:0] rd;
        logic [2:0] f3;
        logic wen;
        int sh;
        ins = m_imem[m_pc[9:2]];
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        nxt = m_pc + 4; wen = 0; val = 0;
        case (op)
            7'h37: begin wen = 1; val = {ins[31:12], 12'b0}; end
            7'h17: begin wen = 1; val = m_pc + {ins[31:12], 12'b0}; end
            7'h6F: begin wen = 1; val = m_pc + 4;
                         nxt = m_pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
            7'h67: if (f3 == 0) begin wen = 1; val = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                if ((f3 == 0 && a == b) || (f3 == 1 && a != b) ||
                    (f3 == 4 && $signed(a) < $signed(b)) || (f3 == 5 && $signed(a) >= $signed(b)) ||
                    (f3 == 6 && a < b) || (f3 == 7 && a >= b))
                    nxt = m_pc + ib;
            end
            7'h03: if (f3 == 2) begin ea = a + ii; wen = 1; val = m_dmem[ea[9:2]]; end
            7'h23: if (f3 == 2) begin ea = a + is; m_dmem[ea[9:2]] = b; end
            7'h13, 7'h33: begin
                if (op == 7'h13) b = ii;
                sh = int'(b[4:0]);
                wen = 1;
                case (f3)
                    0: begin
                        if (op == 7'h33 && f7 == 7'h20) val = a - b;
                        else begin val = a + b; if (op == 7'h33 && f7 != 0) wen = 0; end
                    end
                    1: begin val = a << sh; if (f7 != 0) wen = 0; end
                    2: begin val = ($signed(a) < $signed(b)) ? 1 : 0; if (op == 7'h33 && f7 != 0) wen = 0; end
                    3: begin val = (a < b) ? 1 : 0; if (op == 7'h33 && f7 != 0) wen = 0; end
                    4: begin val = a ^ b; if (op == 7'h33 && f7 != 0) wen = 0; end
                    5: begin
                        if (f7 == 7'h20) val = $unsigned($signed(a) >>> sh);
                        else val = a >> sh;
                        if (f7 != 0 && f7 != 7'h20) wen = 0;
                    end
                    6: begin val = a | b; if (op == 7'h33 && f7 != 0) wen = 0; end
                    default: begin val = a & b; if (op == 7'h33 && f7 != 0) wen = 0; end
                endcase
            end
            default: ;
        endcase
        if (wen && rd != 0) m_x[rd] = val;
        m_pc = nxt;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0] f3;
        logic [6:0] f7;
        rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
        imm = 12'($urandom); f3 = 3'($urandom_range(0, 7));
        f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
        case ($urandom_range(0, 11))
            0: return f_u(20'($urandom), rd, 7'h37);
            1: return f_u(20'($urandom), rd, 7'h17);
            2: return f_j(21'($urandom) & 21'h1FFFFE, rd);
            3: return f_i(imm, rs1, ($urandom_range(0, 4) == 0) ? f3 : 3'd0, rd, 7'h67);
            4: return f_b(13'($urandom) & 13'h1FFE, rs2, rs1, f3);
            5: return f_i(imm, rs1, ($urandom_range(0, 4) == 0) ? f3 : 3'd2, rd, 7'h03);
            6: return f_s(imm, rs2, rs1, ($urandom_range(0, 4) == 0) ? f3 : 3'd2);
            7, 8: return f_i((f3 == 1 || f3 == 5) ? {f7, rs2} : imm, rs1, f3, rd, 7'h13);
            9, 10: return f_r(f7, rs2, rs1, f3, rd, 7'h33);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        clear_imem();
        put(0, f_i(12'd5, 0, 3'd0, 1, 7'h13));
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++; if (disp_an_o !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", disp_an_o); end
            total++; if (disp_seg_o !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", disp_seg_o); end
            total++; if (dut.r_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", dut.r_pc); end
        end
        reset = 1'b1;
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            total++;
            if (disp_an_o !== ((k <= 4) ? 8'hFE : 8'hFD)) begin
                bad++; $display("FAIL reset_scan_start cycle=%0d got=%h exp=%h", k, disp_an_o, (k <= 4) ? 8'hFE : 8'hFD);
            end
        end
        total++; if (dut.r_regs[1] !== 32'd5) begin bad++; $display("FAIL first_instr x1 got=%h exp=5", dut.r_regs[1]); end
    endtask

    task automatic test_alu();
        clear_imem();
        put(0, f_i(12'd5, 0, 3'd0, 1, 7'h13));
        put(1, f_i(12'hFFD, 1, 3'd0, 2, 7'h13));
        put(2, f_r(7'h00, 2, 1, 3'd0, 3, 7'h33));
        put(3, f_r(7'h20, 1, 2, 3'd0, 4, 7'h33));
        put(4, f_i(12'd7, 0, 3'd0, 0, 7'h13));
        apply_reset();
        step(5);
        total++; if (dut.r_regs[1] !== 32'd5) begin bad++; $display("FAIL alu_x1 got=%h exp=5", dut.r_regs[1]); end
        total++; if (dut.r_regs[2] !== 32'd2) begin bad++; $display("FAIL alu_x2 got=%h exp=2", dut.r_regs[2]); end
        total++; if (dut.r_regs[3] !== 32'd7) begin bad++; $display("FAIL alu_x3 got=%h exp=7", dut.r_regs[3]); end
        total++; if (dut.r_regs[4] !== 32'hFFFF_FFFD) begin bad++; $display("FAIL alu_x4 got=%h exp=fffffffd", dut.r_regs[4]); end
        total++; if (dut.r_regs[0] !== 32'd0) begin bad++; $display("FAIL alu_x0 got=%h exp=0", dut.r_regs[0]); end
        total++; if (dut.r_pc !== 32'd20) begin bad++; $display("FAIL alu_pc got=%h exp=14", dut.r_pc); end
    endtask

    task automatic test_mem();
        clear_imem();
        set_dmem(2, 32'hDEAD_BEEF);
        put(0, f_i(12'h055, 0, 3'd0, 5, 7'h13));
        put(1, f_s(12'd8, 5, 0, 3'd2));
        put(2, f_i(12'd8, 0, 3'd2, 6, 7'h03));
        apply_reset();
        step(3);
        total++; if (dut.dataMem[2] !== 32'h55) begin bad++; $display("FAIL sw_dmem2 got=%h exp=55", dut.dataMem[2]); end
        total++; if (dut.r_regs[6] !== 32'h55) begin bad++; $display("FAIL lw_x6 got=%h exp=55", dut.r_regs[6]); end
    endtask

    task automatic test_branch_jump();
        logic [31:0] exp_pc [6];
        exp_pc = '{32'h8, 32'hC, 32'h10, 32'h1C, 32'h14, 32'h18};
        clear_imem();
        put(0, f_b(13'd8, 0, 0, 3'd0));
        put(1, f_i(12'd1, 0, 3'd0, 9, 7'h13));
        put(2, f_b(13'd8, 0, 0, 3'd1));
        put(3, f_i(12'd2, 0, 3'd0, 10, 7'h13));
        put(4, f_j(21'd12, 1));
        put(5, f_i(12'd3, 0, 3'd0, 11, 7'h13));
        put(7, f_i(12'd0, 1, 3'd0, 0, 7'h67));
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step(1);
            total++;
            if (dut.r_pc !== exp_pc[k]) begin bad++; $display("FAIL branch_pc step=%0d got=%h exp=%h", k, dut.r_pc, exp_pc[k]); end
        end
        total++; if (dut.r_regs[9]  !== 32'd0)   begin bad++; $display("FAIL beq_skip x9 got=%h exp=0", dut.r_regs[9]); end
        total++; if (dut.r_regs[10] !== 32'd2)   begin bad++; $display("FAIL bne_fall x10 got=%h exp=2", dut.r_regs[10]); end
        total++; if (dut.r_regs[1]  !== 32'h14)  begin bad++; $display("FAIL jal_link x1 got=%h exp=14", dut.r_regs[1]); end
        total++; if (dut.r_regs[11] !== 32'd3)   begin bad++; $display("FAIL jalr_target x11 got=%h exp=3", dut.r_regs[11]); end
    endtask

    task automatic test_wrap_illegal();
        clear_imem();
        put(0, f_j(21'h3FC, 0));
        put(255, f_i(12'd9, 0, 3'd0, 7, 7'h13));
        apply_reset();
        step(1);
        total++; if (dut.r_pc !== 32'h3FC) begin bad++; $display("FAIL wrap_pc0 got=%h exp=3fc", dut.r_pc); end
        step(1);
        total++; if (dut.r_pc !== 32'h400) begin bad++; $display("FAIL wrap_pc1 got=%h exp=400", dut.r_pc); end
        total++; if (dut.r_regs[7] !== 32'd9) begin bad++; $display("FAIL wrap_x7 got=%h exp=9", dut.r_regs[7]); end
        step(1);
        total++; if (dut.r_pc !== 32'h7FC) begin bad++; $display("FAIL wrap_fetch0 got=%h exp=7fc", dut.r_pc); end

        clear_imem();
        set_dmem(0, 32'h0000_1234);
        put(0, f_i(12'd7, 0, 3'd0, 1, 7'h13));
        put(1, 32'hFFFF_FFFF);
        put(2, f_r(7'h01, 1, 1, 3'd0, 1, 7'h33));
        put(3, f_i({7'h20, 5'd1}, 1, 3'd1, 1, 7'h13));
        put(4, f_i(12'd0, 0, 3'd0, 1, 7'h03));
        put(5, f_b(13'd8, 0, 0, 3'd2));
        put(6, f_i(12'd4, 1, 3'd1, 2, 7'h67));
        put(7, f_s(12'd0, 1, 0, 3'd0));
        apply_reset();
        step(8);
        total++; if (dut.r_pc !== 32'd32) begin bad++; $display("FAIL illegal_pc got=%h exp=20", dut.r_pc); end
        total++; if (dut.r_regs[1] !== 32'd7) begin bad++; $display("FAIL illegal_x1 got=%h exp=7", dut.r_regs[1]); end
        total++; if (dut.r_regs[2] !== 32'd0) begin bad++; $display("FAIL illegal_x2 got=%h exp=0", dut.r_regs[2]); end
        total++; if (dut.r_regs[31] !== 32'd0) begin bad++; $display("FAIL illegal_x31 got=%h exp=0", dut.r_regs[31]); end
        total++; if (dut.dataMem[0] !== 32'h1234) begin bad++; $display("FAIL illegal_dmem0 got=%h exp=1234", dut.dataMem[0]); end
    endtask

    task automatic test_display();
        logic [15:0] sel [4];
        logic [31:0] expv [4];
        logic [7:0]  onehot, exp_seg;
        int idx, prev, dwell;
        bit seen;
        sel  = '{16'h000E, 16'h0000, 16'h0001, 16'h0013};
        expv = '{32'h1234_5678, 32'd16, 32'h0000_006F, 32'hEDCB_A987};
        clear_imem();
        put(0, f_u(20'h12345, 3, 7'h37));
        put(1, f_i(12'h678, 3, 3'd0, 3, 7'h13));
        put(2, f_i(12'hFFF, 3, 3'd4, 4, 7'h13));
        put(3, f_s(12'd16, 4, 0, 3'd2));
        put(4, f_j(21'd0, 0));
        apply_reset();
        step(6);
        for (int s = 0; s < 4; s++) begin
            switches = sel[s];
            repeat (2) @(posedge clk);
            #1;
            prev = -1; dwell = 0; seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                idx = -1;
                for (int j = 0; j < 8; j++) begin
                    onehot = 8'd1 << j;
                    if (disp_an_o === ~onehot) idx = j;
                end
                total++;
                if (idx < 0) begin
                    bad++; $display("FAIL disp_an_onehot sel=%h got=%h", sel[s], disp_an_o);
                end else begin
                    exp_seg = {1'b1, glyph(4'((expv[s] >> (idx * 4)) & 32'hF))};
                    total++;
                    if (disp_seg_o !== exp_seg) begin
                        bad++; $display("FAIL disp_seg sel=%h digit=%0d got=%h exp=%h", sel[s], idx, disp_seg_o, exp_seg);
                    end
                    if (prev < 0) dwell = 1;
                    else if (idx == prev) dwell++;
                    else begin
                        total++;
                        if (idx != (prev + 1) % 8) begin
                            bad++; $display("FAIL disp_order got=%0d exp=%0d", idx, (prev + 1) % 8);
                        end
                        if (seen) begin
                            total++;
                            if (dwell != 4) begin bad++; $display("FAIL disp_dwell got=%0d exp=4", dwell); end
                        end
                        seen = 1; dwell = 1;
                    end
                    prev = idx;
                end
            end
        end
        switches = 16'h0000;
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) put(i, rand_instr());
            for (int i = 0; i < 256; i++) set_dmem(i, $urandom);
            apply_reset();
            for (int c = 0; c < 150; c++) begin
                step(1);
                total++;
                if (dut.r_pc !== m_pc) begin bad++; $display("FAIL rand_pc run=%0d cyc=%0d got=%h exp=%h", r, c, dut.r_pc, m_pc); end
                for (int i = 0; i < 32; i++) begin
                    total++;
                    if (dut.r_regs[i] !== m_x[i]) begin
                        bad++; $display("FAIL rand_reg run=%0d cyc=%0d x%0d got=%h exp=%h", r, c, i, dut.r_regs[i], m_x[i]);
                    end
                end
            end
            for (int i = 0; i < 256; i++) begin
                total++;
                if (dut.dataMem[i] !== m_dmem[i]) begin
                    bad++; $display("FAIL rand_dmem run=%0d word=%0d got=%h exp=%h", r, i, dut.dataMem[i], m_dmem[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_wrap_illegal();
        test_display();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
